lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit directly downstream of the execute ALU.
- Consumes the ALU result as the effective address and the second register operand as store data.
- Drives a single-port data-memory request/acknowledge interface and returns load data, sign- or zero-extended, to writeback.
- Stalls execute while a memory access is outstanding.

Parameters:
D_WIDTH, 32, data/address width; only 32 is supported (byte-enable and lane logic assume 4 byte lanes).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
ex_valid  input  1  execute stage presents an instruction this cycle
ex_ready  output  1  LSU can accept; execute stalls when low
memread  input  1  instruction is a load
memwrite  input  1  instruction is a store
funct3  input  3  access size/sign (RV32I load/store encoding)
aluout  input  D_WIDTH  effective byte address from ALU
regop2  input  D_WIDTH  store data (unshifted)
mem_req  output  1  memory request valid
mem_we  output  1  1 = write, 0 = read
mem_addr  output  D_WIDTH  word address (bits [1:0] forced to 0)
mem_wdata  output  D_WIDTH  lane-aligned store data
mem_be  output  4  byte enables
mem_ack  input  1  memory completes request this cycle
mem_rdata  input  D_WIDTH  read data, valid when mem_ack=1
done  output  1  one-cycle pulse: access completed
wb_we  output  1  with done: load result valid for register write
wb_data  output  D_WIDTH  extended load data
err  output  1  one-cycle pulse: misaligned or illegal access, no memory request issued

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous, active-low.
- States: IDLE, REQ, DONE. Reset forces IDLE asynchronously.
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, done=0, wb_we=0, wb_data=0, err=0. ex_ready=1 (combinational: high only in IDLE).
- Accept: in IDLE with ex_valid=1 and exactly one of memread/memwrite. No-op if ex_valid=0 or both are 0.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Error cases (err pulses the next cycle, state stays IDLE, no mem_req): memread=memwrite=1, any other funct3, halfword with aluout[0]=1, word with aluout[1:0]!=0.
- Legal accept: register mem_we, mem_addr={aluout[31:2],2'b00}, mem_be, mem_wdata, funct3, aluout[1:0]; go to REQ.
- Lane rules (a = aluout[1:0]):
  - SB: be=4'b0001<<a, wdata={4{regop2[7:0]}}.
  - SH: be = a[1] ? 4'b1100 : 4'b0011, wdata={2{regop2[15:0]}}.
  - SW: be=4'b1111, wdata=regop2.
  - Loads: be set the same way as the equivalent store size.
- REQ: mem_req=1; mem_we/addr/wdata/be held stable until mem_ack sampled high. On ack → DONE. A load captures mem_rdata in the ack cycle.
- Load extraction: byte lane a (LB/LBU) or halfword lane a[1] (LH/LHU); sign-extend for LB/LH, zero-extend for LBU/LHU, LW passes through.
- DONE (one cycle): done=1; wb_we=1 for loads, 0 for stores; wb_data valid for loads, 0 for stores. mem_req=0; → IDLE.
- Latency: accept at cycle N → mem_req high at N+1; ack at cycle M≥N+1 → done at M+1 → ex_ready high at M+2.
  - Zero-wait memory: 3 cycles per access; no back-to-back overlap.
- mem_ack in IDLE or DONE is ignored. mem_req never deasserts in REQ before ack.
- err and done are never high together. err never blocks ex_ready.
- Reset mid-REQ: mem_req drops immediately (asynchronous), transaction abandoned, no done, no err.

Test Plan:
- SW aluout=0x100, regop2=0xDEADBEEF, ack after 2 wait cycles → mem_req held 3 cycles, mem_addr=0x100, be=1111, wdata=0xDEADBEEF; done=1, wb_we=0; ex_ready low 4 cycles.
- LB aluout=0x203, mem_rdata=0x80FF_1234 with immediate ack → be=1000, wb_data=0xFFFFFF80, wb_we=1, done exactly one cycle, 3-cycle occupancy; repeat as LBU → 0x00000080.
- SH aluout=0x42, regop2=0x0000ABCD → mem_addr=0x40, be=1100, wdata=0xABCDABCD; LH from same address with rdata=0x7FFF0000 → wb_data=0x00007FFF.
- LW aluout=0x102, also SH aluout=0x101, also funct3=011 → err pulse next cycle, mem_req never asserts, ex_ready stays 1; memread=memwrite=1 → err.
- Assert rst_n low in REQ while mem_ack=0 → mem_req=0 same cycle; after release ex_ready=1, a subsequent LW completes normally with no stale done.
- Stray mem_ack=1 pulses while IDLE, and ex_valid=1 with memread=memwrite=0 → no state change, no done/err, mem_req stays 0.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: turns an ALU effective address plus store data into a
// single-port memory request, and returns extended load data to writeback.
module lsu #(
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic               memread,
    input  logic               memwrite,
    input  logic [2:0]         funct3,
    input  logic [D_WIDTH-1:0] aluout,
    input  logic [D_WIDTH-1:0] regop2,
    output logic               mem_req,
    output logic               mem_we,
    output logic [D_WIDTH-1:0] mem_addr,
    output logic [D_WIDTH-1:0] mem_wdata,
    output logic [3:0]         mem_be,
    input  logic               mem_ack,
    input  logic [D_WIDTH-1:0] mem_rdata,
    output logic               done,
    output logic               wb_we,
    output logic [D_WIDTH-1:0] wb_data,
    output logic               err
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t             state_q;
    logic               mem_req_q;
    logic               mem_we_q;
    logic [D_WIDTH-1:0] mem_addr_q;
    logic [D_WIDTH-1:0] mem_wdata_q;
    logic [3:0]         mem_be_q;
    logic               done_q;
    logic               wb_we_q;
    logic [D_WIDTH-1:0] wb_data_q;
    logic               err_q;
    logic [2:0]         funct3_q;
    logic [1:0]         off_q;

    logic               illegal_d;
    logic [3:0]         be_d;
    logic [D_WIDTH-1:0] wdata_d;
    logic [D_WIDTH-1:0] load_d;
    logic [7:0]         lane_byte;
    logic [15:0]        lane_half;

    // Decode the presented access: legality, alignment, byte enables and lane data.
    always_comb begin
        illegal_d = 1'b0;
        if (memread && memwrite)
            illegal_d = 1'b1;
        else if (memread && !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
            illegal_d = 1'b1;
        else if (memwrite && !(funct3 inside {3'b000, 3'b001, 3'b010}))
            illegal_d = 1'b1;
        else if (funct3[1:0] == 2'b01 && aluout[0])
            illegal_d = 1'b1;
        else if (funct3[1:0] == 2'b10 && aluout[1:0] != 2'b00)
            illegal_d = 1'b1;

        case (funct3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << aluout[1:0];
                wdata_d = {4{regop2[7:0]}};
            end
            2'b01: begin
                be_d    = aluout[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{regop2[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = regop2;
            end
        endcase
    end

    // Pick the addressed lane from the returned word and extend it.
    always_comb begin
        case (off_q)
            2'b00:   lane_byte = mem_rdata[7:0];
            2'b01:   lane_byte = mem_rdata[15:8];
            2'b10:   lane_byte = mem_rdata[23:16];
            default: lane_byte = mem_rdata[31:24];
        endcase
        lane_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (funct3_q)
            3'b000:  load_d = {{(D_WIDTH-8){lane_byte[7]}}, lane_byte};
            3'b001:  load_d = {{(D_WIDTH-16){lane_half[15]}}, lane_half};
            3'b100:  load_d = {{(D_WIDTH-8){1'b0}}, lane_byte};
            3'b101:  load_d = {{(D_WIDTH-16){1'b0}}, lane_half};
            default: load_d = mem_rdata;
        endcase
    end

    // Access sequencer with registered memory and writeback outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= 4'b0000;
            done_q      <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_data_q   <= '0;
            err_q       <= 1'b0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
        end else begin
            done_q  <= 1'b0;
            wb_we_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ex_valid && (memread || memwrite)) begin
                        if (illegal_d) begin
                            err_q <= 1'b1;
                        end else begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= memwrite;
                            mem_addr_q  <= {aluout[D_WIDTH-1:2], 2'b00};
                            mem_be_q    <= be_d;
                            mem_wdata_q <= wdata_d;
                            funct3_q    <= funct3;
                            off_q       <= aluout[1:0];
                            state_q     <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        wb_we_q   <= !mem_we_q;
                        wb_data_q <= mem_we_q ? '0 : load_d;
                        state_q   <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ex_ready  = (state_q == IDLE);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign done      = done_q;
    assign wb_we     = wb_we_q;
    assign wb_data   = wb_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_lsu.sv
// Randomized and directed bench for the load/store unit against a
// behavioural access model.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_ready, memread, memwrite;
    logic [2:0]  funct3;
    logic [31:0] aluout, regop2;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, wb_data;
    logic [3:0]  mem_be;
    logic        done, wb_we, err;

    int n_checks = 0;
    int n_pass   = 0;

    lsu #(.D_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .memread(memread), .memwrite(memwrite), .funct3(funct3),
        .aluout(aluout), .regop2(regop2), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .done(done), .wb_we(wb_we),
        .wb_data(wb_data), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: is the access rejected?
    function automatic bit model_err(input bit rd, input bit wr, input logic [2:0] f3,
                                     input logic [31:0] a);
        int sz;
        if (rd && wr) return 1;
        if (rd && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 1;
        if (wr && f3 > 2) return 1;
        sz = 1 << f3[1:0];
        return (a % sz) != 0;
    endfunction

    // Reference: byte enables, lane data and load result from size/offset arithmetic.
    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int sz = 1 << f3[1:0];
        return 4'(((1 << sz) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3[1:0] == 0) return (d & 32'hFF) * 32'h0101_0101;
        if (f3[1:0] == 1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rdat);
        int sz = 1 << f3[1:0];
        longint v;
        if (sz == 4) return rdat;
        v = (rdat >> (8 * (a % 4))) & ((64'd1 << (8 * sz)) - 1);
        if (f3[2] == 1'b0 && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
        return 32'(v);
    endfunction

    // One full access from acceptance to the cycle after completion.
    task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          input int waits, input logic [31:0] rdat);
        logic [31:0] exp_wb;
        chk("ready_before", 32'(ex_ready), 32'd1);
        ex_valid = 1'b1; memread = rd; memwrite = wr; funct3 = f3; aluout = a; regop2 = d;
        step();
        ex_valid = 1'b0; aluout = $urandom; regop2 = $urandom; funct3 = 3'($urandom);
        if (model_err(rd, wr, f3, a)) begin
            chk("err_pulse", 32'(err), 32'd1);
            chk("err_no_req", 32'(mem_req), 32'd0);
            chk("err_no_done", 32'(done), 32'd0);
            chk("err_ready", 32'(ex_ready), 32'd1);
            step();
            chk("err_clear", 32'(err), 32'd0);
            chk("err_no_req2", 32'(mem_req), 32'd0);
            $display("access rd=%0b wr=%0b f3=%0d a=%08h -> err", rd, wr, f3, a);
            return;
        end
        for (int w = 0; w <= waits; w++) begin
            chk("req", 32'(mem_req), 32'd1);
            chk("req_ready", 32'(ex_ready), 32'd0);
            chk("we", 32'(mem_we), 32'(wr));
            chk("addr", mem_addr, a & ~32'd3);
            chk("be", 32'(mem_be), 32'(model_be(f3, a)));
            if (wr) chk("wdata", mem_wdata, model_wdata(f3, d));
            chk("req_no_done", 32'(done), 32'd0);
            mem_ack   = (w == waits);
            mem_rdata = (w == waits) ? rdat : $urandom;
            step();
        end
        mem_ack = 1'b0; mem_rdata = $urandom;
        exp_wb = wr ? 32'd0 : model_load(f3, a, rdat);
        chk("done", 32'(done), 32'd1);
        chk("wb_we", 32'(wb_we), 32'(rd));
        chk("wb_data", wb_data, exp_wb);
        chk("done_no_req", 32'(mem_req), 32'd0);
        chk("done_no_err", 32'(err), 32'd0);
        chk("done_ready", 32'(ex_ready), 32'd0);
        step();
        chk("done_clear", 32'(done), 32'd0);
        chk("ready_after", 32'(ex_ready), 32'd1);
        $display("access rd=%0b wr=%0b f3=%0d a=%08h d=%08h waits=%0d wb=%08h", rd, wr, f3, a,
                 d, waits, exp_wb);
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; memread = 1'b0; memwrite = 1'b0; funct3 = 3'd0;
        aluout = 32'd0; regop2 = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        step(); step();
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wbwe", 32'(wb_we), 32'd0);
        chk("rst_wbdata", wb_data, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_ready", 32'(ex_ready), 32'd1);
        rst_n = 1'b1;
        step();

        // Directed cases
        access(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 2, 32'h0);
        access(1, 0, 3'b000, 32'h203, 32'h0, 0, 32'h80FF1234);
        access(1, 0, 3'b100, 32'h203, 32'h0, 0, 32'h80FF1234);
        access(0, 1, 3'b001, 32'h42, 32'h0000ABCD, 1, 32'h0);
        access(1, 0, 3'b001, 32'h42, 32'h0, 0, 32'h7FFF0000);
        access(1, 0, 3'b010, 32'h102, 32'h0, 0, 32'h0);
        access(0, 1, 3'b001, 32'h101, 32'h0, 0, 32'h0);
        access(1, 0, 3'b011, 32'h100, 32'h0, 0, 32'h0);
        access(1, 1, 3'b010, 32'h100, 32'h0, 0, 32'h0);

        // Stray acks and no-op presentations while idle
        for (int i = 0; i < 4; i++) begin
            ex_valid = 1'b1; memread = 1'b0; memwrite = 1'b0; mem_ack = 1'b1;
            step();
            chk("idle_req", 32'(mem_req), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_err", 32'(err), 32'd0);
            chk("idle_ready", 32'(ex_ready), 32'd1);
        end
        ex_valid = 1'b0; mem_ack = 1'b0;
        $display("stray ack / no-op idle cycles checked");

        // Reset while a request is outstanding
        ex_valid = 1'b1; memread = 1'b1; memwrite = 1'b0; funct3 = 3'b010; aluout = 32'h300;
        step();
        ex_valid = 1'b0;
        chk("mid_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_req_drop", 32'(mem_req), 32'd0);
        chk("async_ready", 32'(ex_ready), 32'd1);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_done", 32'(done), 32'd0);
        chk("post_rst_err", 32'(err), 32'd0);
        $display("reset during REQ abandoned access");
        access(1, 0, 3'b010, 32'h300, 32'h0, 1, 32'h12345678);

        // Randomized accesses
        for (int i = 0; i < 150; i++) begin
            bit rd, wr;
            int sel = $urandom_range(0, 9);
            rd = (sel < 5) || (sel == 9);
            wr = (sel >= 5);
            access(rd, wr, 3'($urandom), $urandom, $urandom, $urandom_range(0, 3), $urandom);
            if ($urandom_range(0, 3) == 0) step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
